// File: rtl/ternary_hazard_unit_pkg.sv
// Shared definitions for the ternary hazard unit: trit encodings, register
// address helpers, FSM state encoding and multiply-counter width.
package ternary_hazard_unit_pkg;

    localparam int unsigned TRIT_W    = 2;
    localparam int unsigned N_TRITS   = 3;
    localparam int unsigned ADDR_W    = TRIT_W * N_TRITS;
    localparam int unsigned MUL_CNT_W = 4;

    // Two bits per trit; 2'b11 is unused.
    localparam logic [TRIT_W-1:0] T_ZERO = 2'b00;
    localparam logic [TRIT_W-1:0] T_POS  = 2'b01;
    localparam logic [TRIT_W-1:0] T_NEG  = 2'b10;

    // Hard-wired zero register: all three trits zero.
    localparam logic [ADDR_W-1:0] T_R0 = {T_ZERO, T_ZERO, T_ZERO};

    typedef enum logic {
        HZ_IDLE     = 1'b0,
        HZ_MUL_BUSY = 1'b1
    } hz_state_e;

    // Register address compare, trit by trit.
    function automatic logic ternary_addr_eq(input logic [ADDR_W-1:0] a,
                                             input logic [ADDR_W-1:0] b);
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < int'(N_TRITS); i++) begin
            if (a[i*TRIT_W +: TRIT_W] != b[i*TRIT_W +: TRIT_W]) begin
                eq = 1'b0;
            end
        end
        return eq;
    endfunction

endpackage

// File: rtl/ternary_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), inc (count this cycle),
//        clr (sync clear), count (holds at all-ones).
module ternary_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ternary_hazard_unit.sv
// Pipeline hazard/stall controller for the ternary CPU: load-use stalls,
// multi-cycle multiply occupancy, data-memory freeze and branch flushes.
// Ports: pipeline status from ID/EX/MEM in; stall/flush/bubble controls for
// PC, IF/ID, ID/EX, EX/MEM, MEM/WB out (combinational from state + inputs);
// mul_busy; saturating stall_cycles / flush_count performance counters.
module ternary_hazard_unit #(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [5:0]           id_rs1,
    input  logic [5:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_valid,
    input  logic [5:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_mul_start,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_stall,
    output logic                 id_ex_flush,
    output logic                 ex_mem_stall,
    output logic                 ex_mem_bubble,
    output logic                 mem_wb_stall,
    output logic                 mul_busy,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    import ternary_hazard_unit_pkg::*;

    localparam logic MUL_MULTI = (MUL_LATENCY > 1);

    hz_state_e            state_q, state_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    logic freeze;
    logic load_use;
    logic mul_start;

    // Hazard terms
    assign freeze    = mem_req & ~mem_ready;
    assign mul_start = ex_valid & ex_mul_start & MUL_MULTI;
    assign load_use  = ex_valid & ex_mem_read & id_valid
                     & ~ternary_addr_eq(ex_rd, T_R0)
                     & ((id_uses_rs1 & ternary_addr_eq(id_rs1, ex_rd))
                      | (id_uses_rs2 & ternary_addr_eq(id_rs2, ex_rd)));

    assign mul_busy = (state_q == HZ_MUL_BUSY);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HZ_IDLE;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Next state and pipeline controls
    always_comb begin
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_stall  = 1'b0;

        // Frozen cycles leave the FSM and down-counter untouched.
        case (state_q)
            HZ_IDLE: begin
                if (mul_start && !freeze) begin
                    state_d   = HZ_MUL_BUSY;
                    mul_cnt_d = MUL_CNT_W'(MUL_LATENCY - 2);
                end
            end
            HZ_MUL_BUSY: begin
                if (!freeze) begin
                    if (mul_cnt_q == '0) begin
                        state_d = HZ_IDLE;
                    end else begin
                        mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
                    end
                end
            end
            default: state_d = HZ_IDLE;
        endcase

        if (rst) begin
            // all controls stay low
        end else if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if ((state_q == HZ_IDLE) && ex_valid && ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (((state_q == HZ_IDLE) && mul_start)
                  || ((state_q == HZ_MUL_BUSY) && (mul_cnt_q != '0))) begin
            // Final busy cycle (count zero) releases so the product advances.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    ternary_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    ternary_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .clr   (1'b0),
        .count (flush_count)
    );

endmodule

// File: tb/tb_ternary_hazard_unit.sv
// Scoreboard bench for ternary_hazard_unit (MUL_LATENCY=3, CNT_WIDTH=4).
// Driver applies one directed vector per cycle and queues its expectation;
// monitor pops and checks on the falling edge.
module tb_ternary_hazard_unit;

    import ternary_hazard_unit_pkg::*;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_uses_rs1, id_uses_rs2;
    logic [5:0] id_rs1, id_rs2, ex_rd;
    logic ex_valid, ex_mem_read, ex_mul_start, ex_branch_taken;
    logic mem_req, mem_ready;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, ex_mem_bubble, mem_wb_stall, mul_busy;
    logic [CW-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    ternary_hazard_unit #(.MUL_LATENCY(3), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_mul_start    (ex_mul_start),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .ex_mem_bubble   (ex_mem_bubble),
        .mem_wb_stall    (mem_wb_stall),
        .mul_busy        (mul_busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [5:0] id_rs1;
        logic [5:0] id_rs2;
        logic       u1;
        logic       u2;
        logic       ex_valid;
        logic [5:0] ex_rd;
        logic       mr;
        logic       ms;
        logic       bt;
        logic       mq;
        logic       mrdy;
    } in_t;

    typedef struct {
        int            id;
        logic [8:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    // {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //  ex_mem_stall, ex_mem_bubble, mem_wb_stall, mul_busy}
    localparam logic [8:0] E_NONE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] E_LU   = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] E_BR   = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] E_MUL  = 9'b1_1_0_1_0_0_1_0_0;
    localparam logic [8:0] E_FRZ  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] BUSY   = 9'b0_0_0_0_0_0_0_0_1;

    localparam logic [5:0] RD   = {T_POS, T_ZERO, T_NEG};
    localparam logic [5:0] R_NN = {T_NEG, T_NEG, T_NEG};

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    function automatic in_t quiet();
        in_t v;
        v = '0;
        v.mrdy = 1'b1;
        return v;
    endfunction

    function automatic in_t lu_vec(input logic [5:0] rd);
        in_t v;
        v = quiet();
        v.ex_valid = 1'b1;
        v.mr       = 1'b1;
        v.ex_rd    = rd;
        v.id_valid = 1'b1;
        v.id_rs1   = R_NN;
        v.u1       = 1'b1;
        v.id_rs2   = rd;
        v.u2       = 1'b1;
        return v;
    endfunction

    function automatic in_t mul_vec(input logic frz, input logic r);
        in_t v;
        v = quiet();
        v.rst      = r;
        v.ex_valid = 1'b1;
        v.ms       = 1'b1;
        v.ex_rd    = RD;
        v.mq       = frz;
        v.mrdy     = ~frz;
        return v;
    endfunction

    function automatic in_t br_vec(input logic frz);
        in_t v;
        v = lu_vec(RD);
        v.mr   = 1'b1;
        v.bt   = 1'b1;
        v.mq   = frz;
        v.mrdy = ~frz;
        return v;
    endfunction

    function automatic in_t rst_vec();
        in_t v;
        v = quiet();
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rst             = v.rst;
        id_valid        = v.id_valid;
        id_rs1          = v.id_rs1;
        id_rs2          = v.id_rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_valid        = v.ex_valid;
        ex_rd           = v.ex_rd;
        ex_mem_read     = v.mr;
        ex_mul_start    = v.ms;
        ex_branch_taken = v.bt;
        mem_req         = v.mq;
        mem_ready       = v.mrdy;
    endtask

    // One cycle: apply vector, queue expectation, advance past next edge.
    task automatic step(input in_t v, input logic [8:0] ctl, input int sc, input int fc);
        exp_t e;
        drive(v);
        e.id  = step_id;
        e.ctl = ctl;
        e.sc  = CW'(sc);
        e.fc  = CW'(fc);
        sb_q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] act;
        assert (!(ex_mul_start && ex_branch_taken))
            else $error("illegal ex_mul_start with ex_branch_taken");
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, ex_mem_bubble, mem_wb_stall, mul_busy};
            n_cmp++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl step %0d: got %b expected %b", e.id, act, e.ctl);
            end
            n_cmp++;
            if (stall_cycles !== e.sc) begin
                n_fail++;
                $display("FAIL stall_cycles step %0d: got %0d expected %0d", e.id, stall_cycles, e.sc);
            end
            n_cmp++;
            if (flush_count !== e.fc) begin
                n_fail++;
                $display("FAIL flush_count step %0d: got %0d expected %0d", e.id, flush_count, e.fc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        drive(rst_vec());
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step(rst_vec(), E_NONE, 0, 0);
        // load-use on rs2, then a clean cycle shows the counted stall
        step(lu_vec(RD), E_LU, 0, 0);
        step(quiet(), E_NONE, 1, 0);
        // R0 destination never hazards
        step(lu_vec(T_R0), E_NONE, 1, 0);
        // taken branch outranks load-use
        step(br_vec(1'b0), E_BR, 1, 0);
        step(quiet(), E_NONE, 1, 1);
        // multiply, latency 3
        step(mul_vec(1'b0, 1'b0), E_MUL, 1, 1);
        step(mul_vec(1'b0, 1'b0), E_MUL | BUSY, 2, 1);
        step(mul_vec(1'b0, 1'b0), BUSY, 3, 1);
        step(quiet(), E_NONE, 3, 1);
        // multiply with a 4-cycle freeze mid-busy
        step(mul_vec(1'b0, 1'b0), E_MUL, 3, 1);
        step(mul_vec(1'b1, 1'b0), E_FRZ | BUSY, 4, 1);
        step(mul_vec(1'b1, 1'b0), E_FRZ | BUSY, 5, 1);
        step(mul_vec(1'b1, 1'b0), E_FRZ | BUSY, 6, 1);
        step(mul_vec(1'b1, 1'b0), E_FRZ | BUSY, 7, 1);
        step(mul_vec(1'b0, 1'b0), E_MUL | BUSY, 8, 1);
        step(mul_vec(1'b0, 1'b0), BUSY, 9, 1);
        step(quiet(), E_NONE, 9, 1);
        // branch held under freeze, flushed once released
        step(br_vec(1'b1), E_FRZ, 9, 1);
        step(br_vec(1'b0), E_BR, 10, 1);
        step(quiet(), E_NONE, 10, 2);
        // reset mid-busy
        step(mul_vec(1'b0, 1'b0), E_MUL, 10, 2);
        step(mul_vec(1'b0, 1'b1), BUSY, 11, 2);
        step(quiet(), E_NONE, 0, 0);
        // counter saturation at 4 bits
        for (int k = 0; k < 20; k++) begin
            step(lu_vec(RD), E_LU, (k < 15) ? k : 15, 0);
        end
        step(quiet(), E_NONE, 15, 0);

        for (int t = 0; t < 10 && sb_q.size() > 0; t++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
